// File: rtl/dmem_arbiter_pkg.sv
// Shared types, widths and the byte-merge helper for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int WORD_W    = 32;
    localparam int STRB_W    = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    // Byte-wise select: strobed bytes come from new_w, the rest from old_w.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] res;
        for (int i = 0; i < STRB_W; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign gnt_idx = gnt[1];

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-addressed data memory between two valid/ready requesters and
// emulates byte-strobe writes with a two-cycle read-modify-write.
//
//   state  | meaning
//   IDLE   | arbitrating; accepts one request per cycle
//   RMW_WR | writing back the merged word of a partial write
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_DEPTH = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

    state_e      state_q, state_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] addr_q, addr_d;
    logic        port_q, port_d;

    logic [1:0]  gnt;
    logic        g;
    logic        arb_en;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_strb;
    logic        sel_we;
    logic        in_range;

    assign arb_en = rst_n && (state_q == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .enable  (arb_en),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (g)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    assign sel_addr  = g ? req_addr[63:32]  : req_addr[31:0];
    assign sel_wdata = g ? req_wdata[63:32] : req_wdata[31:0];
    assign sel_strb  = g ? req_wstrb[7:4]   : req_wstrb[3:0];
    assign sel_we    = g ? req_we[1]        : req_we[0];
    assign in_range  = sel_addr[31:2] < DEPTH_W;

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 32'h0;
        merge_d      = merge_q;
        addr_d       = addr_q;
        port_d       = port_q;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        rsp_valid_d[g] = 1'b1;
                        rsp_err_d      = 1'b1;
                    end else if (!sel_we) begin
                        mem_read_en    = 1'b1;
                        mem_addr       = sel_addr;
                        rsp_rdata_d    = mem_rdata;
                        rsp_valid_d[g] = 1'b1;
                    end else if (sel_strb == 4'hF) begin
                        mem_write_en   = 1'b1;
                        mem_addr       = sel_addr;
                        mem_wdata      = sel_wdata;
                        rsp_valid_d[g] = 1'b1;
                    end else if (sel_strb == 4'h0) begin
                        rsp_valid_d[g] = 1'b1;
                    end else begin
                        mem_read_en = 1'b1;
                        mem_addr    = sel_addr;
                        merge_d     = merge_bytes(mem_rdata, sel_wdata, sel_strb);
                        addr_d      = sel_addr;
                        port_d      = g;
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // A reset landing here abandons the write-back entirely.
                if (rst_n) begin
                    mem_write_en        = 1'b1;
                    mem_addr            = addr_q;
                    mem_wdata           = merge_q;
                    rsp_valid_d[port_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            merge_q     <= 32'h0;
            addr_q      <= 32'h0;
            port_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
            port_q      <= port_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory (synchronous write, asynchronous read) between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: loader/DMA.
- Arbitrates round-robin and uses valid/ready request handshakes.
- Adds byte-strobe writes, which the memory lacks, via a two-cycle read-modify-write sequence.
- Sits between the requesters and data_memory.

Parameters:
- MEM_DEPTH, 8192: memory depth in 32-bit words. Word index addr[31:2] >= MEM_DEPTH is out of range.
- NUM_PORTS, 2: number of requesters. The design is fixed at 2; the parameter exists for the package and for checks.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  2  per-port request valid.
- req_ready  output  2  per-port accept; combinational from state, req_valid and last_grant.
- req_we  input  2  per-port write (1) / read (0).
- req_addr  input  64  port p at bits [32p+31:32p]; byte address, bits [1:0] ignored.
- req_wdata  input  64  port p at bits [32p+31:32p].
- req_wstrb  input  8  port p at bits [4p+3:4p]; byte enables, ignored for reads.
- rsp_valid  output  2  one-cycle completion pulse per port; at most one bit set per cycle.
- rsp_err  output  1  qualifies rsp_valid: access was out of range.
- rsp_rdata  output  32  read data for the port flagged in rsp_valid; 0 for writes and errors.
- mem_read_en  output  1  to data_memory read_en.
- mem_write_en  output  1  to data_memory write_en.
- mem_addr  output  32  to data_memory addr.
- mem_wdata  output  32  to data_memory write_data.
- mem_rdata  input  32  from data_memory read_data_out; valid in the same cycle as mem_addr.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, merge register=0.
  - While rst_n=0: req_ready=0, mem_write_en=0, mem_read_en=0.
- States:
  - IDLE: accepting.
  - RMW_WR: second cycle of a partial write.
- Arbitration, IDLE only:
  - One port valid → grant it.
  - Both valid → grant !last_grant.
  - req_ready[g]=1 only for the grantee. Accept = req_valid[g] & req_ready[g]. last_grant<=g on accept.
  - Requesters hold all request fields stable until accepted.
- Accept-cycle actions (memory signals driven combinationally from the granted port; mem_addr = req_addr):
  - Out of range → no memory enable. Next cycle: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - Read → mem_read_en=1; mem_rdata registered. Next cycle: rsp_valid[g]=1, rsp_rdata=data. Latency 1.
  - Write, wstrb=4'hF → mem_write_en=1, mem_wdata=req_wdata. Next cycle: rsp_valid[g]=1. Latency 1.
  - Write, wstrb=4'h0 → no memory access. Next cycle: rsp_valid[g]=1.
  - Write, other wstrb:
    - Accept cycle: mem_read_en=1. Merge register <= per byte i, wstrb[i] ? wdata byte : mem_rdata byte. Register g and addr. state → RMW_WR.
    - RMW_WR cycle: req_ready=00, mem_write_en=1, mem_addr=held addr, mem_wdata=merge. Next cycle: rsp_valid[g]=1, state → IDLE.
    - Latency 2.
- Memory signals outside these cases: mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0.
- Back-to-back: a new accept may occur in the same cycle as the previous rsp_valid pulse. Sustained throughput is 1 access/cycle, except partial writes at 1 per 2 cycles.
- Address handling: addr[1:0] never affects memory. The range check uses addr[31:2].
- Reset mid-RMW (rst_n=0 during RMW_WR): mem_write_en=0 in that cycle. Memory is unchanged, no rsp_valid is issued, and the next state is IDLE.
- Starvation: while both ports stay valid, grants strictly alternate.

Decomposition:
- Package dmem_arbiter_pkg:
  - state enum {IDLE, RMW_WR}.
  - NUM_PORTS, WORD_W=32, STRB_W=4.
  - Function merge_bytes(old, new, strb).
- Sub-module rr_arb2: 2-requester round-robin.
  - Inputs: clk, rst_n, req[1:0], enable, advance.
  - Outputs: gnt[1:0] one-hot, gnt_idx.
  - Owns last_grant.

Test Plan:
- Read after reset: mem[5]=32'hDEADBEEF preloaded; p0 read addr 0x14 → p0 accepted in cycle 0; next cycle rsp_valid=01, rsp_rdata=DEADBEEF, rsp_err=0.
- Contention: both ports valid for 4 consecutive read requests each, held → grant order p0,p1,p0,p1,…; no port ever waits more than one accept while valid.
- Partial write: mem[2]=32'h11223344; p1 write addr 0x08, wdata=32'hAABBCCDD, wstrb=4'b0101.
  - Expect: mem_read_en in cycle 0, mem_write_en in cycle 1, req_ready=00 in cycle 1, rsp_valid=10 in cycle 2.
  - Expect mem[2]=32'h11BB33DD afterwards.
- Full write then read back: p0 write 0x100, wstrb F, data 32'hCAFEF00D, then p0 read 0x103 → rsp_rdata=CAFEF00D (low address bits ignored).
- Out of range: p0 read addr 32'h00008000 (word 8192) → no mem enables; rsp_valid=01, rsp_err=1, rsp_rdata=0. wstrb=0 write → rsp with no mem_write_en.
- Reset during RMW_WR: assert rst_n=0 in the RMW_WR cycle → mem_write_en=0, target word unchanged, no rsp_valid, state IDLE; first tie after release → p0.
